muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide unit and HI/LO register owner for the pipelined CPU. It executes MULT, MULTU, DIV and DIVU over 33 busy cycles, holds the HI/LO architectural registers, and services MTHI/MTLO writes. It raises a combinational stall toward the hazard logic whenever the decode stage needs HI/LO or the unit while it is busy. It sits beside the ALU in the execute stage, driven by decode signals derived from the control unit.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request a new mul/div operation this cycle.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  32  multiplicand / dividend (rs).
- src_b  in  32  multiplier / divisor (rt).
- flush  in  1  abort any in-flight operation (branch/jump squash).
- rd_req  in  1  decode holds MFHI or MFLO.
- wr_hi  in  1  MTHI write enable.
- wr_lo  in  1  MTLO write enable.
- wdata  in  32  MTHI/MTLO data.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO just updated by a mul/div.
- div_zero  out  1  sticky flag: last completed DIV/DIVU had src_b == 0.
- stall  out  1  combinational: busy & (start | rd_req | wr_hi | wr_lo).

## Operation
- States: IDLE, RUN, FIX.
- IDLE with start=1 and flush=0:
  - Latch op.
  - Latch |src_a| and |src_b| (magnitudes for signed ops, raw values for unsigned).
  - Latch the sign bits.
  - Clear the 6-bit iteration counter.
  - Go to RUN.
- RUN: one iteration per cycle.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 32-bit remainder, quotient shifted into LO side.
  - After iteration 32, go to FIX.
- FIX, multiply: negate the 64-bit product if the signs differ (MULT only).
- FIX, divide:
  - Quotient is negated if the signs differ (DIV only).
  - Remainder takes the dividend's sign (DIV only).
- End of FIX:
  - Write HI (product[63:32] / remainder) and LO (product[31:0] / quotient).
  - Set div_zero for DIV/DIVU when the latched divisor was 0; clear it for other completed ops.
  - Pulse done; return to IDLE.
- Divide by zero: no special path; the restoring algorithm yields quotient 0xFFFFFFFF and remainder = |dividend|, then FIX sign rules apply. Full latency still applies.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0; no trap.
- start while busy: ignored; stall=1 so the pipeline holds and re-presents the request.
- MTHI/MTLO in IDLE: HI/LO take wdata at the clock edge.
  - wr_hi and wr_lo may both be asserted; both registers are written.
  - MTHI/MTLO in the same IDLE cycle as start: the start wins; the write is dropped.
- Any request while busy has no effect beyond stall; HI/LO are never written mid-operation.
- flush in RUN or FIX:
  - Go to IDLE at the next edge; busy=0.
  - HI, LO, div_zero unchanged; no done.
  - flush in IDLE blocks a same-cycle start.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0; stall=0 follows from busy=0.
- Reset assertion mid-operation aborts immediately, asynchronously.
- Start sampled at edge k:
  - busy=1 from edge k through edge k+33.
  - RUN spans edges k+1..k+32; FIX ends at edge k+33.
  - New HI/LO are visible after edge k+33, together with busy=0 and done=1 for that cycle only.
- A start presented in the done cycle is accepted; back-to-back throughput is 1 op per 34 cycles.
- MFHI issued in the done cycle reads the new value with no stall.
- stall is purely combinational from registered busy and the current inputs; no output depends combinationally on src_a/src_b.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 busy cycles HI=0xFFFFFFFE, LO=0x00000001, done pulses once.
- MULT 0xFFFFFFFD (-3) × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, div_zero=0.
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064, div_zero=1. A following MULTU 2×3 then gives LO=6 and clears div_zero.
- Busy interlock:
  - start plus rd_req at busy cycle 5 -> stall=1, no second op started.
  - wr_hi with wdata=0x1234 at busy cycle 6 -> HI unchanged.
  - MTHI 0x1234 after done -> HI=0x1234.
- Abort and reset:
  - flush at busy cycle 10 -> busy=0 next cycle, HI/LO keep prior values, no done.
  - rst_n low mid-operation -> all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative 32-bit multiply/divide unit. It also owns the HI/LO architectural
// registers. MULT/MULTU/DIV/DIVU take 33 busy cycles: 32 RUN iterations and
// one FIX cycle that applies the signs and commits HI/LO. MTHI/MTLO write the
// registers while the unit is idle.
//
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_start, i_op[1:0]      request: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_src_a, i_src_b        rs (multiplicand/dividend), rt (multiplier/divisor)
//   i_flush                 abort the in-flight op, block a same-cycle start
//   i_rd_req                decode holds MFHI/MFLO
//   i_wr_hi, i_wr_lo        MTHI/MTLO enables, data on i_wdata
//   o_hi, o_lo              HI/LO registers
//   o_busy, o_done          op in flight / one-cycle commit pulse
//   o_div_zero              sticky: last completed div had a zero divisor
//   o_stall                 busy & (start | rd_req | wr_hi | wr_lo)
module muldiv_sequencer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  input  logic        i_flush,
  input  logic        i_rd_req,
  input  logic        i_wr_hi,
  input  logic        i_wr_lo,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_div_zero,
  output logic        o_stall
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

  state_t      r_state, w_next;
  logic        r_is_div, r_sa, r_sb;
  logic [31:0] r_opnd;   // |multiplicand| for mul, |divisor| for div
  logic [63:0] r_acc;    // mul: {partial, multiplier}; div: {rem, dividend/quotient}
  logic [5:0]  r_cnt;
  logic [31:0] r_hi, r_lo;
  logic        r_done, r_div_zero;

  logic        w_accept, w_sa_in, w_sb_in;
  logic [31:0] w_abs_a, w_abs_b;
  logic [32:0] w_madd;
  logic [63:0] w_mul_nxt;
  logic [32:0] w_shift;
  logic [31:0] w_rem_sub;
  logic        w_ge;
  logic [63:0] w_div_nxt;
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem;

  assign o_busy     = (r_state != S_IDLE);
  assign o_stall    = o_busy & (i_start | i_rd_req | i_wr_hi | i_wr_lo);
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
  assign o_done     = r_done;
  assign o_div_zero = r_div_zero;

  assign w_accept = (r_state == S_IDLE) & i_start & ~i_flush;

  // Only signed ops (op[0]==0) carry a sign; unsigned latch zero signs, so FIX
  // can apply its rules without looking at the op again.
  assign w_sa_in = ~i_op[0] & i_src_a[31];
  assign w_sb_in = ~i_op[0] & i_src_b[31];
  assign w_abs_a = w_sa_in ? (~i_src_a + 32'd1) : i_src_a;
  assign w_abs_b = w_sb_in ? (~i_src_b + 32'd1) : i_src_b;

  // Radix-2 shift-add: add the multiplicand to the upper half on LSB=1, shift right.
  assign w_madd    = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_nxt = {w_madd, r_acc[31:1]};

  // Restoring divide. {rem, next dividend bit} can reach 33 bits, but when the
  // subtract succeeds the difference always fits in 32.
  assign w_shift   = r_acc[63:31];
  assign w_ge      = (w_shift >= {1'b0, r_opnd});
  assign w_rem_sub = w_shift[31:0] - r_opnd;
  assign w_div_nxt = {(w_ge ? w_rem_sub : w_shift[31:0]), r_acc[30:0], w_ge};

  assign w_prod = (r_sa ^ r_sb) ? (~r_acc + 64'd1) : r_acc;
  assign w_quo  = (r_sa ^ r_sb) ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rem  = r_sa ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (i_flush) w_next = S_IDLE;
               else if (r_cnt == 6'd31) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_is_div   <= 1'b0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // A start wins over a same-cycle MTHI/MTLO.
            r_is_div <= i_op[1];
            r_sa     <= w_sa_in;
            r_sb     <= w_sb_in;
            r_opnd   <= i_op[1] ? w_abs_b : w_abs_a;
            r_acc    <= {32'd0, (i_op[1] ? w_abs_a : w_abs_b)};
            r_cnt    <= '0;
          end else begin
            if (i_wr_hi) r_hi <= i_wdata;
            if (i_wr_lo) r_lo <= i_wdata;
          end
        end
        S_RUN: begin
          if (!i_flush) begin
            r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_FIX: begin
          if (!i_flush) begin
            r_hi       <= r_is_div ? w_rem : w_prod[63:32];
            r_lo       <= r_is_div ? w_quo : w_prod[31:0];
            r_div_zero <= r_is_div & (r_opnd == 32'd0);
            r_done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, flush, rd_req, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic [31:0] hi, lo;
  logic        busy, done, dz, stall;

  muldiv_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_src_a(src_a), .i_src_b(src_b), .i_flush(flush), .i_rd_req(rd_req),
    .i_wr_hi(wr_hi), .i_wr_lo(wr_lo), .i_wdata(wdata),
    .o_hi(hi), .o_lo(lo), .o_busy(busy), .o_done(done),
    .o_div_zero(dz), .o_stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  int   n_pass = 0;
  int   n_tot  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain arithmetic. Signed division truncates toward zero and the
  // remainder follows the dividend. A zero divisor gives quotient all-ones
  // (negated when the dividend is negative) and remainder = dividend.
  function automatic exp_t model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(ma);
    sb = $signed(mb);
    e.cyc = 0;
    e.dz  = 1'b0;
    case (mop)
      2'd0: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin p = {32'd0, ma} * {32'd0, mb}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd2: begin
        e.dz = (mb == 0);
        if (mb == 0) begin
          e.lo = ma[31] ? 32'd1 : 32'hFFFF_FFFF;
          e.hi = ma;
        end else begin
          q = sa / sb;
          r = sa % sb;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end
      end
      default: begin
        e.dz = (mb == 0);
        if (mb == 0) begin e.lo = 32'hFFFF_FFFF; e.hi = ma; end
        else begin e.lo = ma / mb; e.hi = ma % mb; end
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        m_e = sb_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(m_e.cyc));
        chk("hi", {32'd0, hi}, {32'd0, m_e.hi});
        chk("lo", {32'd0, lo}, {32'd0, m_e.lo});
        chk("div_zero", {63'd0, dz}, {63'd0, m_e.dz});
      end
    end
  end

  // Called at a negedge; holds start for one edge and returns at the next
  // negedge (first busy cycle).
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
    exp_t e;
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (expect_done) begin
      e = model(o, a, b);
      e.cyc = cyc + 34;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; src_a = $urandom; src_b = $urandom;
  endtask

  // Counts busy cycles; ends on the negedge of the done cycle.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  logic [1:0]  d_op [8] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd1, 2'd2, 2'd2, 2'd3};
  logic [31:0] d_a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100,
                            32'd2, 32'h8000_0000, 32'hFFFF_FFF9, 32'hDEAD_BEEF};
  logic [31:0] d_b  [8] = '{32'hFFFF_FFFF, 32'd5, 32'd2, 32'd0,
                            32'd3, 32'hFFFF_FFFF, 32'd0, 32'd16};

  initial begin
    int n;
    rst_n = 1'b0; start = 0; flush = 0; rd_req = 0; wr_hi = 0; wr_lo = 0;
    op = 0; src_a = 0; src_b = 0; wdata = 0;
    #3;
    chk("rst_hi", {32'd0, hi}, 0);
    chk("rst_lo", {32'd0, lo}, 0);
    chk("rst_busy_done_dz_stall", {60'd0, busy, done, dz, stall}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // MTHI+MTLO together, then MTLO alone
    wr_hi = 1; wr_lo = 1; wdata = 32'hA5A5_0001;
    @(negedge clk); wr_hi = 0; wr_lo = 0;
    chk("mt_both_hi", {32'd0, hi}, 64'hA5A5_0001);
    chk("mt_both_lo", {32'd0, lo}, 64'hA5A5_0001);
    wr_lo = 1; wdata = 32'd2;
    @(negedge clk); wr_lo = 0;
    chk("mtlo_lo", {32'd0, lo}, 64'd2);
    chk("mtlo_hi_kept", {32'd0, hi}, 64'hA5A5_0001);

    // idle requests never stall
    rd_req = 1; wr_hi = 0; #1;
    chk("idle_no_stall", {63'd0, stall}, 0);
    rd_req = 0;

    // flush in idle blocks a start
    start = 1; flush = 1; op = 2'd1; src_a = 3; src_b = 3;
    @(negedge clk); start = 0; flush = 0;
    chk("flush_blocks_start", {63'd0, busy}, 0);
    @(negedge clk);

    // directed ops back to back, each started in the previous done cycle
    for (int i = 0; i < 8; i++) begin
      issue(d_op[i], d_a[i], d_b[i], 1);
      wait_idle(n);
      chk("latency", 64'(n), 64'd33);
    end

    // busy interlock: the MULTU gives hi=3, lo=0
    @(negedge clk);
    issue(2'd1, 32'h0001_0000, 32'h0003_0000, 1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 3) begin #1; chk("busy_quiet_no_stall", {63'd0, stall}, 0); end
      if (n == 5) begin
        start = 1; op = 2'd3; rd_req = 1; #1;
        chk("stall_start_rd", {63'd0, stall}, 1);
      end
      if (n == 6) begin
        start = 0; rd_req = 0; wr_hi = 1; wdata = 32'h1234; #1;
        chk("stall_wr_hi", {63'd0, stall}, 1);
      end
      if (n == 7) wr_hi = 0;
      @(negedge clk);
    end
    chk("interlock_latency", 64'(n), 64'd33);
    chk("interlock_hi_not_written", {32'd0, hi}, 64'd3);
    @(negedge clk);
    wr_hi = 1; wdata = 32'h1234;
    @(negedge clk); wr_hi = 0;
    chk("mthi_after_done", {32'd0, hi}, 64'h1234);

    // MTHI in the same cycle as start is dropped
    wr_hi = 1; wdata = 32'hBAD;
    issue(2'd1, 32'd2, 32'd3, 1);
    wr_hi = 0;
    chk("mthi_dropped_on_start", {32'd0, hi}, 64'h1234);
    wait_idle(n);
    chk("latency_mthi_start", 64'(n), 64'd33);

    // flush at busy cycle 10: HI=0, LO=6 must survive, no done
    @(negedge clk);
    issue(2'd3, 32'd1000, 32'd7, 0);
    n = 1;
    while (n < 10) begin n++; @(negedge clk); end
    flush = 1;
    @(negedge clk); flush = 0;
    chk("flush_busy_low", {63'd0, busy}, 0);
    repeat (40) @(negedge clk);
    chk("flush_hi_kept", {32'd0, hi}, 64'd0);
    chk("flush_lo_kept", {32'd0, lo}, 64'd6);

    // randomized ops
    for (int i = 0; i < 30; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), 1);
      wait_idle(n);
      chk("rand_latency", 64'(n), 64'd33);
    end

    // reset mid-op after a known nonzero HI/LO
    @(negedge clk);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    wait_idle(n);
    @(negedge clk);
    issue(2'd0, $urandom, $urandom, 0);
    repeat (6) @(negedge clk);
    rd_req = 1;
    rst_n = 1'b0; #1;
    chk("arst_hi", {32'd0, hi}, 0);
    chk("arst_lo", {32'd0, lo}, 0);
    chk("arst_busy_done_dz_stall", {60'd0, busy, done, dz, stall}, 0);
    @(negedge clk); rst_n = 1'b1; rd_req = 0;
    repeat (40) @(negedge clk);
    chk("no_done_after_reset", {63'd0, done}, 0);

    chk("scoreboard_empty", 64'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
